// File: rtl/tmds_pkg.sv
// Shared TMDS constants and types, common to the encoder and the DDR serializer.
// Exports: SYM_W, NUM_LANES, CLK_SYM, CTRL_SYM[4], sym_set_t, sym_pair().
// No ports; combinational helper only.
package tmds_pkg;

  localparam int SYM_W     = 10;
  localparam int NUM_LANES = 3;

  // Clock-lane pattern: five ones then five zeros, sent LSB first.
  localparam logic [SYM_W-1:0] CLK_SYM = 10'b0000011111;

  // Control-period symbols, indexed by {C1,C0}.
  localparam logic [SYM_W-1:0] CTRL_SYM [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  typedef logic [NUM_LANES-1:0][SYM_W-1:0] sym_set_t;

  // Bit pair p of a symbol: {odd bit (falling edge), even bit (rising edge)}.
  function automatic logic [1:0] sym_pair(input logic [SYM_W-1:0] sym, input logic [2:0] p);
    return sym[{p, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/tmds_ddr_serializer_if.sv
// Upstream symbol-set handshake between the TMDS encoders and the serializer.
// Signals: i_valid (set valid), o_ready (serializer can accept), i_sym (LANES*10 set).
// Names are from the serializer's point of view; master = encoder side, slave = serializer.
interface tmds_ddr_serializer_if #(
  parameter int LANES = 3
);
  import tmds_pkg::*;

  logic                   i_valid;
  logic                   o_ready;
  logic [LANES*SYM_W-1:0] i_sym;

  modport master (output i_valid, output i_sym, input o_ready);
  modport slave  (input i_valid, input i_sym, output o_ready);

endinterface

// File: rtl/tmds_sym_fifo.sv
// Synchronous symbol-set FIFO with registered full/empty and no fall-through.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_dat, i_pop/o_dat (head), o_full, o_empty.
// Push while full and pop while empty are ignored; DEPTH must be a power of 2, >= 2.
module tmds_sym_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 30
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_cnt_nxt;

  // Gating on the registered flags is what prevents fall-through: a set
  // pushed into an empty FIFO cannot be popped in the same cycle.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/tmds_ddr_serializer.sv
// TMDS symbol sets -> ODDRX1F D0/D1 bit pairs in the 5x shift clock domain, one set per 5 cycles.
// Ports: i_clk, i_rst (sync, active-high), up (slave: i_valid/o_ready/i_sym), o_d0/o_d1
// ([LANES] = clock lane), o_load (word loaded), o_underrun (sticky), i_clr_underrun.
module tmds_ddr_serializer
  import tmds_pkg::*;
#(
  parameter int               LANES      = 3,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [SYM_W-1:0] IDLE_SYM   = 10'b1101010100
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  tmds_ddr_serializer_if.slave  up,
  output logic [LANES:0]        o_d0,
  output logic [LANES:0]        o_d1,
  output logic                  o_load,
  output logic                  o_underrun,
  input  logic                  i_clr_underrun
);

  logic [2:0]             r_phase;
  // One 10-bit word per lane; the pair is selected by phase rather than
  // physically shifted, so a reload is a plain overwrite.
  logic [SYM_W-1:0]       r_sr [LANES+1];
  logic                   r_started;
  logic                   r_underrun;

  logic                   w_boundary;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [LANES*SYM_W-1:0] w_head;

  assign w_boundary = (r_phase == 3'd4);
  assign w_push     = up.i_valid && up.o_ready;
  assign w_pop      = w_boundary && !w_empty;
  // Ready comes only from the registered full flag: no path from i_valid.
  assign up.o_ready = !w_full;

  tmds_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LANES*SYM_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_dat   (up.i_sym),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_boundary ? 3'd0 : r_phase + 3'd1;
    end
  end

  // The pair leaving in this cycle is registered, so pair p of a word is
  // on the pins during phase p+1; pair 4 lands in phase 0 of the next word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < LANES; k++) r_sr[k] <= IDLE_SYM;
      r_sr[LANES] <= CLK_SYM;
      o_d0        <= '0;
      o_d1        <= '0;
      o_load      <= 1'b0;
    end else begin
      for (int k = 0; k <= LANES; k++) begin
        {o_d1[k], o_d0[k]} <= sym_pair(r_sr[k], r_phase);
      end
      if (w_boundary) begin
        for (int k = 0; k < LANES; k++) begin
          r_sr[k] <= w_empty ? IDLE_SYM : w_head[k*SYM_W +: SYM_W];
        end
        r_sr[LANES] <= CLK_SYM;
      end
      o_load <= w_boundary;
    end
  end

  // Underrun only counts once real data has flowed; a set beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_started  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_pop) r_started <= 1'b1;
      if (w_boundary && w_empty && r_started) begin
        r_underrun <= 1'b1;
      end else if (i_clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign o_underrun = r_underrun;

endmodule
